// File: rtl/detector_jogada.sv
// Button input stage: 2-flop sync, debounce, one-hot acceptance, release wait.
// Optional DETECTOR_CONTAGEM_EN adds the db_num_jogadas accepted-play counter.
module detector_jogada #(
  parameter int N_BOTOES = 4,
  parameter int DEBOUNCE = 50000,
  parameter int CW       = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                tem_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic                multipla,
  output logic                ocupado,
  output logic [2:0]          db_estado
`ifdef DETECTOR_CONTAGEM_EN
  ,
  output logic [7:0]          db_num_jogadas
`endif
);

  // Handshake: tem_jogada is a one-cycle valid with no ready; the consumer
  // must sample jogada in that cycle (jogada stays stable afterwards anyway).
  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ESTABILIZA = 3'd1,
    PULSO      = 3'd2,
    REJEITA    = 3'd3,
    SOLTURA    = 3'd4
  } estado_t;

  localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE - 1);

  estado_t             estado, proxEstado;
  logic [N_BOTOES-1:0] sinc1, sinc;
  logic [N_BOTOES-1:0] candidato, proxCandidato;
  logic [N_BOTOES-1:0] proxJogada;
  logic [CW-1:0]       contador, proxContador;
  logic                candidatoUnico;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1 <= '0;
      sinc  <= '0;
    end else begin
      sinc1 <= botoes;
      sinc  <= sinc1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      candidato <= '0;
      contador  <= '0;
      jogada    <= '0;
    end else begin
      estado    <= proxEstado;
      candidato <= proxCandidato;
      contador  <= proxContador;
      jogada    <= proxJogada;
    end
  end

  assign candidatoUnico = (candidato != '0) &&
                          ((candidato & (candidato - 1'b1)) == '0);

  always_comb begin
    proxEstado    = estado;
    proxCandidato = candidato;
    proxContador  = contador;
    proxJogada    = jogada;
    case (estado)
      OCIOSO: begin
        if (habilita && sinc != '0) begin
          proxCandidato = sinc;
          proxContador  = '0;
          proxEstado    = ESTABILIZA;
        end
      end
      ESTABILIZA: begin
        if (!habilita || sinc == '0) begin
          proxEstado = OCIOSO;
        end else if (sinc != candidato) begin
          // Bounce or an added button: restart the count on the new pattern.
          proxCandidato = sinc;
          proxContador  = '0;
        end else if (contador == ULTIMO) begin
          if (candidatoUnico) begin
            proxJogada = candidato;
            proxEstado = PULSO;
          end else begin
            proxEstado = REJEITA;
          end
        end else begin
          proxContador = contador + 1'b1;
        end
      end
      PULSO, REJEITA: begin
        proxContador = '0;
        proxEstado   = SOLTURA;
      end
      SOLTURA: begin
        if (sinc != '0) begin
          proxContador = '0;
        end else if (contador == ULTIMO) begin
          proxEstado = OCIOSO;
        end else begin
          proxContador = contador + 1'b1;
        end
      end
      default: proxEstado = OCIOSO;
    endcase
  end

  assign tem_jogada = (estado == PULSO);
  assign multipla   = (estado == REJEITA);
  assign ocupado    = (estado != OCIOSO);
  assign db_estado  = estado;

`ifdef DETECTOR_CONTAGEM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_num_jogadas <= '0;
    end else if (estado == PULSO) begin
      db_num_jogadas <= db_num_jogadas + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Randomized and directed bench for detector_jogada against a run-length model.
module tb_detector_jogada;

  localparam int N = 4;
  localparam int D = 4;

  logic         clock;
  logic         reset;
  logic         habilita;
  logic [N-1:0] botoes;
  logic         tem_jogada;
  logic [N-1:0] jogada;
  logic         multipla;
  logic         ocupado;
  logic [2:0]   db_estado;
  logic [7:0]   db_num_jogadas;

  int nVetores = 0;
  int nErros   = 0;

  detector_jogada #(.N_BOTOES(N), .DEBOUNCE(D), .CW(3)) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .botoes(botoes),
    .tem_jogada(tem_jogada),
    .jogada(jogada),
    .multipla(multipla),
    .ocupado(ocupado),
    .db_estado(db_estado)
`ifdef DETECTOR_CONTAGEM_EN
    ,
    .db_num_jogadas(db_num_jogadas)
`endif
  );

`ifndef DETECTOR_CONTAGEM_EN
  assign db_num_jogadas = 8'd0;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: tracks how many consecutive edges the synchronized
  // pattern has been the same nonzero value while enabled, and how many
  // consecutive quiet edges have been seen since the last decision.
  logic [N-1:0] mSinc1, mSinc2, mPadrao, mJogada;
  int           mRun, mEmit, mQuiet;
  bit           mSoltura;
  logic [7:0]   mNum;

  task automatic modelReset();
    mSinc1 = '0; mSinc2 = '0; mPadrao = '0; mJogada = '0;
    mRun = 0; mEmit = 0; mQuiet = 0; mSoltura = 0; mNum = '0;
  endtask

  task automatic modelEdge();
    logic [N-1:0] s;
    if (!reset) begin
      modelReset();
      return;
    end
    s = mSinc2;
    mSinc2 = mSinc1;
    mSinc1 = botoes;
    if (mEmit != 0) begin
      if (mEmit == 1) mNum = mNum + 8'd1;
      mEmit = 0;
      mSoltura = 1;
      mQuiet = 0;
    end else if (mSoltura) begin
      mQuiet = (s == '0) ? mQuiet + 1 : 0;
      if (mQuiet == D) mSoltura = 0;
    end else begin
      if (habilita && s != '0) begin
        if (mRun > 0 && s == mPadrao) mRun++;
        else begin
          mPadrao = s;
          mRun = 1;
        end
      end else begin
        mRun = 0;
      end
      if (mRun == D + 1) begin
        mRun = 0;
        if ($countones(mPadrao) == 1) begin
          mEmit = 1;
          mJogada = mPadrao;
        end else begin
          mEmit = 2;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nVetores++;
    if (obs !== exp) begin
      nErros++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    logic [2:0] eEstado;
    if (mEmit == 1)      eEstado = 3'd2;
    else if (mEmit == 2) eEstado = 3'd3;
    else if (mSoltura)   eEstado = 3'd4;
    else if (mRun > 0)   eEstado = 3'd1;
    else                 eEstado = 3'd0;
    chk("tem_jogada", {7'd0, tem_jogada}, {7'd0, mEmit == 1});
    chk("multipla",   {7'd0, multipla},   {7'd0, mEmit == 2});
    chk("jogada",     {4'd0, jogada},     {4'd0, mJogada});
    chk("ocupado",    {7'd0, ocupado},    {7'd0, eEstado != 3'd0});
    chk("db_estado",  {5'd0, db_estado},  {5'd0, eEstado});
`ifdef DETECTOR_CONTAGEM_EN
    chk("db_num_jogadas", db_num_jogadas, mNum);
`endif
  endtask

  task automatic ciclo();
    @(posedge clock);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  // Asynchronous abort: outputs must clear without waiting for an edge.
  task automatic pulsoReset();
    reset = 1'b0;
    #1;
    modelReset();
    compareAll();
    botoes = '0;
    ciclos(2);
    reset = 1'b1;
  endtask

  int strobes;
  int lat;

  initial begin
    reset = 1'b1; habilita = 1'b0; botoes = '0;
    modelReset();
    #1 reset = 1'b0;
    #1 compareAll();
    ciclos(2);
    reset = 1'b1;
    ciclos(2);

    // Reset landing in the middle of a debounce count.
    habilita = 1'b1; botoes = 4'b0100;
    ciclos(4);
    pulsoReset();
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      ciclo();
      if (tem_jogada) strobes++;
    end
    chk("rst_no_strobe", 8'(strobes), 8'd0);

    // Clean press, long hold, release.
    botoes = 4'b0100;
    strobes = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      ciclo();
      if (tem_jogada) begin
        strobes++;
        if (lat == 0) lat = i;
      end
    end
    chk("lat_press", 8'(lat), 8'(3 + D));
    chk("held_strobes", 8'(strobes), 8'd1);
    botoes = '0;
    ciclos(D + 4);
    chk("released_idle", {5'd0, db_estado}, 8'd0);

    // Bouncing contact, then a stable hold.
    for (int i = 0; i < 10; i++) begin
      botoes = (i % 4 < 2) ? 4'b0010 : 4'b0000;
      ciclo();
    end
    botoes = 4'b0010;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      ciclo();
      if (tem_jogada) strobes++;
    end
    chk("bounce_strobes", 8'(strobes), 8'd1);
    botoes = '0;
    ciclos(D + 4);

    // Two buttons together are rejected; jogada keeps the last play.
    botoes = 4'b0011;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      ciclo();
      if (multipla) strobes++;
    end
    chk("multi_strobes", 8'(strobes), 8'd1);
    chk("multi_keeps", {4'd0, jogada}, 8'h02);
    botoes = '0;
    ciclos(D + 4);

    // Button already held when habilita rises.
    habilita = 1'b0; botoes = 4'b1000;
    ciclos(10);
    habilita = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      ciclo();
      if (tem_jogada) lat = i;
    end
    chk("lat_habilita", 8'(lat), 8'(D + 1));
    chk("jogada_1000", {4'd0, jogada}, 8'h08);
    habilita = 1'b0;
    ciclo();
    botoes = '0;
    ciclos(D + 4);

    // Randomized segments, including enable drops and occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)      botoes = '0;
      else if (r <= 6) botoes = 4'(1 << $urandom_range(0, N - 1));
      else             botoes = 4'($urandom_range(1, 15));
      habilita = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) pulsoReset();
      ciclos($urandom_range(1, 10));
    end
    botoes = '0;
    ciclos(D + 4);

    $display("== %0d vectors applied, %0d miscompares ==", nVetores, nErros);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input stage directly upstream of the game control unit.
- Synchronizes and debounces the player buttons, and accepts only single-button (one-hot) presses.
- Delivers a one-cycle `tem_jogada` strobe with a stable `jogada` code, which the control unit consumes as `tem_jogada` / `jogadaAtual`.
- Rejects multi-button presses. Requires full release before the next play is accepted.

Parameters:
- N_BOTOES, 4, number of buttons; width of `botoes` and `jogada`.
- DEBOUNCE, 50000, consecutive stable cycles required for both press and release (≥2).
- CW, 16, debounce counter width; must satisfy 2^CW > DEBOUNCE.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- habilita  in  1  capture enable from the control unit (high while it is waiting for a play).
- botoes  in  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- tem_jogada  out  1  one-cycle strobe: a valid play was accepted.
- jogada  out  N_BOTOES  one-hot code of the last accepted play; holds until the next accepted play.
- multipla  out  1  one-cycle strobe: a debounced multi-button press was rejected.
- ocupado  out  1  high in every state except OCIOSO.
- db_estado  out  3  current FSM state code, for debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to OCIOSO; counter = 0; synchronizer flops = 0; candidate register = 0.
  - tem_jogada=0, jogada=0, multipla=0, ocupado=0, db_estado=000.
- Synchronizer: 2-flop per bit on `botoes`. `s` denotes the synchronized vector. The FSM only ever uses `s`.
- FSM states (db_estado codes):
  - OCIOSO (0): if habilita=1 and s≠0 → latch candidate c<=s, counter<=0, go to ESTABILIZA. Otherwise stay.
  - ESTABILIZA (1), checked in this priority order:
    - habilita=0 → OCIOSO.
    - s=0 → OCIOSO.
    - s≠c → c<=s, counter<=0, stay.
    - counter=DEBOUNCE-1 → if c is one-hot, jogada<=c and go to PULSO; otherwise go to REJEITA.
    - else counter+1.
  - PULSO (2): tem_jogada=1 for exactly this cycle → SOLTURA with counter<=0.
  - REJEITA (3): multipla=1 for exactly this cycle; jogada unchanged → SOLTURA with counter<=0.
  - SOLTURA (4): ignores habilita.
    - s≠0 → counter<=0.
    - else if counter=DEBOUNCE-1 → OCIOSO.
    - else counter+1.
  - Any unused code → OCIOSO.
- Outputs are Moore and registered-state derived. jogada is already stable in the cycle tem_jogada is high.
- Latency: a clean press whose edge lands at cycle k yields tem_jogada high in cycle k+3+DEBOUNCE.
- Boundaries:
  - Bounce during ESTABILIZA restarts the count.
  - A second button added mid-count restarts the count with the new pattern.
  - A held button produces exactly one strobe, with no auto-repeat.
  - A press already held when habilita rises is accepted after a full DEBOUNCE from that rise.
  - habilita falling during PULSO or REJEITA has no effect; the strobe still fires.
  - The counter never wraps: it saturates at DEBOUNCE-1 by construction.
  - reset asserted mid-operation aborts instantly, with no strobe emitted.

Optional Feature:
- Macro: DETECTOR_CONTAGEM_EN.
- Defined:
  - Adds output `db_num_jogadas`, 8 bits. Reset value 0.
  - Increments in the cycle after each PULSO and wraps 255→0.
  - Not incremented by REJEITA.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan (DEBOUNCE=4):
- Reset low mid-ESTABILIZA, then released → all outputs 0 and db_estado=000 immediately, with no tem_jogada afterwards.
- habilita=1, botoes=0100 clean press at cycle k → tem_jogada=1 only in cycle k+7, jogada=0100 from that cycle, held for 20 cycles → no further strobe; release → db_estado 4 then 0 after ≥4 quiet cycles.
- botoes toggles 0010/0000 every 2 cycles for 10 cycles, then holds 0010 → exactly one tem_jogada, 7 cycles after the final stable edge.
- botoes=0011 held, habilita=1 → multipla=1 for one cycle, tem_jogada never 1, jogada retains its previous value (e.g. 0100).
- habilita=0 with botoes=1000 held for 10 cycles, then habilita=1 → tem_jogada at the 5th cycle after habilita rises (including the OCIOSO exit cycle), jogada=1000.
- With DETECTOR_CONTAGEM_EN defined: 3 valid presses plus 1 multi-button press → db_num_jogadas=3.
